// File: rtl/router_pkt_gen.sv
// router_pkt_gen: packet source for the 1xN router input port.
// Each packet is a header beat {len, addr}, len LFSR payload beats, then an
// XOR parity trailer. Beats advance only on edges where busy is low.
// Optional build macro ROUTER_PKT_GEN_ERR_INJ_EN adds an err_inj input that
// inverts the parity trailer of the requested packet.
module router_pkt_gen #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 2,
  parameter int                NUM_CH     = 3,
  parameter logic [DATA_W-1:0] SEED       = 8'hA5,
  parameter logic [DATA_W-1:0] POLY       = 8'hB8,
  parameter int                GAP_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [DATA_W-ADDR_W-1:0] cfg_len,
  input  logic [ADDR_W-1:0]        cfg_addr,
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  input  logic                     err_inj,
`endif
  input  logic                     busy,
  output logic [DATA_W-1:0]        data_out,
  output logic                     pkt_valid,
  output logic                     pkt_last,
  output logic                     ready,
  output logic                     done,
  output logic                     addr_err,
  output logic [15:0]              pkt_count
);

  localparam int LEN_W      = DATA_W - ADDR_W;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LOAD_I);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAR, S_GAP} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] parity_q;
  logic [DATA_W-1:0] lfsr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [GAP_W-1:0]  gap_q;
  logic [15:0]       cnt_q;
  logic              vld_q;
  logic              last_q;
  logic              ready_q;
  logic              done_q;
  logic              addr_err_q;

  logic [DATA_W-1:0] lfsr_d;
  logic [DATA_W-1:0] hdr_d;
  logic [DATA_W-1:0] inj_mask;
  logic              addr_ok;

  // Galois right-shift step; only taken on an accepted payload beat.
  assign lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
  assign hdr_d   = {cfg_len, cfg_addr};
  assign addr_ok = (int'(cfg_addr) < NUM_CH);

`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  logic inj_q;

  // Error-inject request is captured with the accepted start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      inj_q <= 1'b0;
    else if (state_q == S_IDLE && ready_q && start && addr_ok)
      inj_q <= err_inj;
  end

  assign inj_mask = {DATA_W{inj_q}};
`else
  assign inj_mask = '0;
`endif

  // Packet sequencer with registered beat outputs; every beat state holds on busy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      parity_q   <= '0;
      lfsr_q     <= SEED;
      rem_q      <= '0;
      gap_q      <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && start) begin
            if (addr_ok) begin
              state_q  <= S_HDR;
              data_q   <= hdr_d;
              parity_q <= hdr_d;
              rem_q    <= cfg_len;
              vld_q    <= 1'b1;
              ready_q  <= 1'b0;
            end else begin
              addr_err_q <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (!busy) begin
            if (rem_q == '0) begin
              // Zero-length packet: trailer is just the header.
              state_q <= S_PAR;
              data_q  <= parity_q ^ inj_mask;
              vld_q   <= 1'b0;
              last_q  <= 1'b1;
            end else begin
              state_q <= S_PAY;
              data_q  <= lfsr_q;
            end
          end
        end
        S_PAY: begin
          if (!busy) begin
            parity_q <= parity_q ^ data_q;
            lfsr_q   <= lfsr_d;
            rem_q    <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              // Trailer must already fold in the beat being accepted now.
              state_q <= S_PAR;
              data_q  <= (parity_q ^ data_q) ^ inj_mask;
              vld_q   <= 1'b0;
              last_q  <= 1'b1;
            end else begin
              data_q <= lfsr_d;
            end
          end
        end
        S_PAR: begin
          if (!busy) begin
            data_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b1;
            cnt_q  <= cnt_q + 16'd1;
            if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
              gap_q   <= GAP_LOAD;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign pkt_valid = vld_q;
  assign pkt_last  = last_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: directed scenarios followed by
// randomized packets, all compared against a packet-level reference model.
module tb_router_pkt_gen;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 2;
  localparam int NUM_CH     = 3;
  localparam int GAP_CYCLES = 2;
  localparam int LEN_W      = DATA_W - ADDR_W;
  localparam logic [7:0] SEED = 8'hA5;
  localparam logic [7:0] POLY = 8'hB8;

  logic              clock = 1'b0;
  logic              resetn = 1'b1;
  logic              start = 1'b0;
  logic              busy = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  logic              err_inj = 1'b0;
`endif
  logic [7:0]        data_out;
  logic              pkt_valid, pkt_last, ready, done, addr_err;
  logic [15:0]       pkt_count;

  router_pkt_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH),
    .SEED(SEED), .POLY(POLY), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .cfg_len(cfg_len), .cfg_addr(cfg_addr),
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .busy(busy), .data_out(data_out), .pkt_valid(pkt_valid),
    .pkt_last(pkt_last), .ready(ready), .done(done),
    .addr_err(addr_err), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state: generator sequence and completed-packet count.
  logic [7:0]  m_lfsr = SEED;
  logic [15:0] m_count = '0;
  logic [7:0]  exp_d[$];
  bit          exp_v[$];
  bit          exp_l[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ntests++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected beat list for one packet: header, len generator values, parity.
  task automatic build(input int len, input int addr, input bit inj);
    logic [7:0] hdr, par;
    exp_d.delete(); exp_v.delete(); exp_l.delete();
    hdr = 8'(len * (1 << ADDR_W) + addr);
    par = hdr;
    exp_d.push_back(hdr); exp_v.push_back(1'b1); exp_l.push_back(1'b0);
    for (int k = 0; k < len; k++) begin
      exp_d.push_back(m_lfsr); exp_v.push_back(1'b1); exp_l.push_back(1'b0);
      par = par ^ m_lfsr;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 8'h00);
    end
    exp_d.push_back(inj ? ~par : par); exp_v.push_back(1'b0); exp_l.push_back(1'b1);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("ready_before_start", 32'(ready), 32'd1);
  endtask

  task automatic send_pkt(input int len, input int addr, input bit inj,
                          input int stall_at, input int stall_n, input bit rnd);
    int i, w, stalls;
    bit b, do_inj;
    do_inj = 1'b0;
    wait_ready();
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    do_inj  = inj;
    err_inj = inj;
`else
    b = inj;
`endif
    build(len, addr, do_inj);
    start = 1'b1; cfg_len = LEN_W'(len); cfg_addr = ADDR_W'(addr);
    tick();
    start = 1'b0;
    i = 0; w = 0; stalls = 0;
    while (i < exp_d.size() && w < 2000) begin
      chk("beat_data", 32'(data_out), 32'(exp_d[i]));
      chk("beat_valid", 32'(pkt_valid), 32'(exp_v[i]));
      chk("beat_last", 32'(pkt_last), 32'(exp_l[i]));
      chk("beat_ready_low", 32'(ready), 32'd0);
      chk("beat_done_low", 32'(done), 32'd0);
      if (i == stall_at && stalls < stall_n) begin
        b = 1'b1;
        stalls++;
      end else if (rnd) begin
        b = ($urandom_range(0, 2) == 0);
        start = 1'($urandom_range(0, 1));
        cfg_len = LEN_W'($urandom);
        cfg_addr = ADDR_W'($urandom);
      end else begin
        b = 1'b0;
      end
      busy = b;
      tick();
      if (!b) i++;
      w++;
    end
    busy = 1'b0;
    chk("all_beats_accepted", 32'(i), 32'(exp_d.size()));
    m_count = m_count + 16'd1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("post_data_zero", 32'(data_out), 32'd0);
    chk("post_last_low", 32'(pkt_last), 32'd0);
    chk("post_valid_low", 32'(pkt_valid), 32'd0);
    chk("pkt_count", 32'(pkt_count), 32'(m_count));
    // start held through the gap must be ignored rather than queued.
    for (int g = 0; g < GAP_CYCLES; g++) begin
      chk("gap_ready_low", 32'(ready), 32'd0);
      if (g > 0) chk("done_one_cycle", 32'(done), 32'd0);
      start = 1'b1;
      tick();
    end
    chk("ready_after_gap", 32'(ready), 32'd1);
    chk("done_after_gap", 32'(done), 32'd0);
    start = 1'b0;
    tick();
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_valid_low", 32'(pkt_valid), 32'd0);
    chk("idle_data_zero", 32'(data_out), 32'd0);
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    err_inj = 1'b0;
`endif
  endtask

  task automatic reject(input int addr);
    wait_ready();
    start = 1'b1; cfg_addr = ADDR_W'(addr); cfg_len = LEN_W'($urandom);
    tick();
    chk("addr_err_pulse", 32'(addr_err), 32'd1);
    chk("reject_valid_low", 32'(pkt_valid), 32'd0);
    chk("reject_ready_high", 32'(ready), 32'd1);
    chk("reject_count", 32'(pkt_count), 32'(m_count));
    start = 1'b0;
    tick();
    chk("addr_err_one_cycle", 32'(addr_err), 32'd0);
    chk("reject_ready_kept", 32'(ready), 32'd1);
    chk("reject_valid_kept", 32'(pkt_valid), 32'd0);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(pkt_valid), 32'd0);
    chk("rst_last", 32'(pkt_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    m_lfsr = SEED;
    m_count = '0;
    busy = 1'b0; start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    chk("ready_after_reset", 32'(ready), 32'd1);
  endtask

  initial begin
    int len, addr;

    // Reset and the reference packet len=3 addr=2.
    do_reset();
    send_pkt(3, 2, 1'b0, -1, 0, 1'b0);

    // Same packet with a 4-cycle stall on the second payload beat.
    do_reset();
    send_pkt(3, 2, 1'b0, 2, 4, 1'b0);

    // Zero-length packet: parity equals the header.
    send_pkt(0, 1, 1'b0, -1, 0, 1'b0);

    // Illegal destination, then the top legal one.
    reject(3);
    send_pkt(1, NUM_CH - 1, 1'b0, 3, 2, 1'b0);

    // Reset in the middle of a payload beat.
    wait_ready();
    start = 1'b1; cfg_len = LEN_W'(5); cfg_addr = '0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_pay_valid", 32'(pkt_valid), 32'd1);
    do_reset();
    send_pkt(2, 0, 1'b0, -1, 0, 1'b0);

`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    do_reset();
    send_pkt(3, 2, 1'b1, -1, 0, 1'b0);
    send_pkt(2, 1, 1'b0, -1, 0, 1'b1);
`endif

    // Randomized packets, stalls and junk inputs while busy with a packet.
    for (int n = 0; n < 25; n++) begin
      len  = $urandom_range(0, 12);
      addr = $urandom_range(0, 3);
      if (addr >= NUM_CH) reject(addr);
      else send_pkt(len, addr, 1'b0, -1, 0, 1'b1);
    end
    send_pkt((1 << LEN_W) - 1, 0, 1'b0, -1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
